// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller for the RV64 ALU: tracks EX/MEM destination tags,
// raises load-use stalls, selects operand forwarding and counts load-use bubbles.
module ex_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_write_back,
    input  logic             id_load,
    input  logic             mem_busy,
    input  logic             flush,
    output logic             stall,
    output logic             issue,
    output logic [1:0]       fwd_rs1,
    output logic [1:0]       fwd_rs2,
    output logic [CNT_W-1:0] lu_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wb;
        logic       load;
    } tag_t;

    localparam tag_t TAG_BUBBLE = '{valid: 1'b0, rd: 5'd0, wb: 1'b0, load: 1'b0};
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    tag_t             ex_q, ex_d;
    tag_t             mem_q, mem_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;

    logic ex_m1_s, ex_m2_s, mem_m1_s, mem_m2_s;
    logic lu_hazard_s;

    // x0 is hard-wired zero, so it can never be a forwarding source.
    function automatic logic tag_match(input tag_t t, input logic [4:0] rs, input logic use_rs);
        return use_rs & (rs != 5'd0) & t.valid & t.wb & (t.rd == rs);
    endfunction

    // EX wins over MEM because it holds the younger value; a load in EX has no data yet.
    function automatic logic [1:0] fwd_sel(input logic ex_m, input logic ex_load,
                                           input logic mem_m, input logic rst);
        logic [1:0] sel;
        if (rst) begin
            sel = FWD_RF;
        end else if (ex_m && !ex_load) begin
            sel = FWD_EX;
        end else if (mem_m) begin
            sel = FWD_MEM;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Hazard detection, stall/issue, forwarding select and next-state computation.
    always_comb begin
        ex_m1_s     = tag_match(ex_q, id_rs1, id_use_rs1);
        ex_m2_s     = tag_match(ex_q, id_rs2, id_use_rs2);
        mem_m1_s    = tag_match(mem_q, id_rs1, id_use_rs1);
        mem_m2_s    = tag_match(mem_q, id_rs2, id_use_rs2);
        lu_hazard_s = id_valid & ~flush & ex_q.load & (ex_m1_s | ex_m2_s);

        stall   = RST | mem_busy | lu_hazard_s;
        issue   = id_valid & ~flush & ~stall;
        fwd_rs1 = fwd_sel(ex_m1_s, ex_q.load, mem_m1_s, RST);
        fwd_rs2 = fwd_sel(ex_m2_s, ex_q.load, mem_m2_s, RST);
        lu_cnt  = lu_cnt_q;

        ex_d     = ex_q;
        mem_d    = mem_q;
        lu_cnt_d = lu_cnt_q;
        if (mem_busy) begin
            ex_d     = ex_q;
            mem_d    = mem_q;
            lu_cnt_d = lu_cnt_q;
        end else begin
            mem_d = ex_q;
            if (issue) begin
                ex_d = '{valid: 1'b1, rd: id_rd, wb: id_write_back, load: id_load};
            end else begin
                ex_d = TAG_BUBBLE;
            end
            if (lu_hazard_s && (lu_cnt_q != {CNT_W{1'b1}})) begin
                lu_cnt_d = lu_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                lu_cnt_d = lu_cnt_q;
            end
        end
    end

    // Tag pipeline and bubble counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ex_q     <= TAG_BUBBLE;
            mem_q    <= TAG_BUBBLE;
            lu_cnt_q <= {CNT_W{1'b0}};
        end else begin
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

endmodule
